// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse packet receiver: synchronised frame capture, start/parity/stop checks,
// 3- or 4-byte packet assembly with timeout resync, decoded deltas behind a one-entry valid/ready stage.
module ps2_mouse_rx #(
  parameter int PACKET_BYTES   = 3,      // 3 (standard) or 4 (wheel)
  parameter int DELTA_WIDTH    = 9,
  parameter bit SATURATE       = 1'b1,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_PS2Clk,
  input  logic                   i_PS2Data,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [DELTA_WIDTH-1:0] o_dx,
  output logic [DELTA_WIDTH-1:0] o_dy,
  output logic [3:0]             o_dz,
  output logic                   o_l_click,
  output logic                   o_r_click,
  output logic                   o_m_click,
  output logic                   o_x_ov,
  output logic                   o_y_ov,
  output logic                   o_frame_err,
  output logic                   o_sync_err,
  output logic                   o_overrun
);

  localparam int         TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] LAST_IDX = 2'(PACKET_BYTES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   ps2_clk_s;
  logic                   ps2_dat_s;
  logic                   fall;

  logic [3:0]      bit_cnt;
  logic [9:0]      shreg;
  logic [1:0]      byte_idx;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  logic [10:0] frame;
  logic [7:0]  rx_byte;
  logic        frame_done;
  logic        frame_ok;
  logic        byte_acc;
  logic        sync_bad;
  logic        pkt_last;

  logic       frame_err_q;
  logic       pkt_done;
  logic [2:0] btn_q;
  logic       xs_q, ys_q, xov_q, yov_q;
  logic [7:0] b1_q, b2_q;
  logic [3:0] b3_q;

  logic [8:0]             dx9, dy9;
  logic [DELTA_WIDTH-1:0] dx_ext, dy_ext;
  logic [3:0]             dz_val;

  assign ps2_clk_s = clk_sync[SYNC_STAGES-1];
  assign ps2_dat_s = dat_sync[SYNC_STAGES-1];
  assign fall      = clk_prev & ~ps2_clk_s;

  // Synchronisers reset to 1 so an idle bus never looks like a falling edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_PS2Clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], i_PS2Data};
      clk_prev <= ps2_clk_s;
    end
  end

  always_comb begin
    to_hit     = (to_cnt == TO_W'(TIMEOUT_CYCLES));
    frame      = {ps2_dat_s, shreg};
    rx_byte    = frame[8:1];
    frame_done = fall & ~to_hit & (bit_cnt == 4'd10);
    frame_ok   = ~frame[0] & (^frame[9:1]) & frame[10];
    byte_acc   = frame_done & frame_ok & ((byte_idx != 2'd0) | rx_byte[3]);
    sync_bad   = frame_done & frame_ok & (byte_idx == 2'd0) & ~rx_byte[3];
    pkt_last   = byte_acc & (byte_idx == LAST_IDX);
  end

  // A timeout wins over a coincident edge: the whole frame/packet is abandoned.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      byte_idx    <= '0;
      to_cnt      <= '0;
      frame_err_q <= 1'b0;
      o_sync_err  <= 1'b0;
      pkt_done    <= 1'b0;
    end else begin
      frame_err_q <= frame_done & ~frame_ok;
      o_sync_err  <= sync_bad;
      pkt_done    <= pkt_last;
      if (to_hit) begin
        bit_cnt  <= '0;
        byte_idx <= '0;
        to_cnt   <= '0;
      end else begin
        if (fall) begin
          shreg   <= {ps2_dat_s, shreg[9:1]};
          bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
        end
        if (frame_done && !frame_ok)
          byte_idx <= '0;
        else if (byte_acc)
          byte_idx <= pkt_last ? 2'd0 : byte_idx + 2'd1;
        if (fall || (bit_cnt == 4'd0 && byte_idx == 2'd0))
          to_cnt <= '0;
        else
          to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      btn_q <= '0;
      xs_q  <= 1'b0;
      ys_q  <= 1'b0;
      xov_q <= 1'b0;
      yov_q <= 1'b0;
      b1_q  <= '0;
      b2_q  <= '0;
      b3_q  <= '0;
    end else if (byte_acc) begin
      case (byte_idx)
        2'd0: begin
          btn_q <= rx_byte[2:0];
          xs_q  <= rx_byte[4];
          ys_q  <= rx_byte[5];
          xov_q <= rx_byte[6];
          yov_q <= rx_byte[7];
        end
        2'd1: b1_q <= rx_byte;
        2'd2: b2_q <= rx_byte;
        2'd3: b3_q <= rx_byte[3:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    dx9 = {xs_q, b1_q};
    dy9 = {ys_q, b2_q};
    if (SATURATE && xov_q) dx9 = xs_q ? 9'h100 : 9'h0FF;
    if (SATURATE && yov_q) dy9 = ys_q ? 9'h100 : 9'h0FF;
    dx_ext = DELTA_WIDTH'($signed(dx9));
    dy_ext = DELTA_WIDTH'($signed(dy9));
    dz_val = (PACKET_BYTES == 4) ? b3_q : 4'h0;
  end

  // One-entry output stage; a packet arriving while the entry is held and not drained is dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_dx      <= '0;
      o_dy      <= '0;
      o_dz      <= '0;
      o_l_click <= 1'b0;
      o_r_click <= 1'b0;
      o_m_click <= 1'b0;
      o_x_ov    <= 1'b0;
      o_y_ov    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (pkt_done) begin
        if (!o_valid || i_ready) begin
          o_valid   <= 1'b1;
          o_dx      <= dx_ext;
          o_dy      <= dy_ext;
          o_dz      <= dz_val;
          o_l_click <= btn_q[0];
          o_r_click <= btn_q[1];
          o_m_click <= btn_q[2];
          o_x_ov    <= xov_q;
          o_y_ov    <= yov_q;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_frame_err = frame_err_q | to_hit;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Scoreboard bench: four receiver configurations fed with bit-banged PS/2 frames.
`timescale 1ns/1ps
module tb_ps2_mouse_rx;

  localparam int HALF = 8;
  localparam int TO   = 100;

  typedef struct packed {
    logic [11:0] dx;
    logic [11:0] dy;
    logic [3:0]  dz;
    logic [2:0]  btn;
    logic [1:0]  ov;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic ps2c_a = 1'b1, ps2d_a = 1'b1, ps2c_b = 1'b1, ps2d_b = 1'b1;
  logic rdy_a = 1'b1, rdy_b = 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, nerr = 0;
  int last_fall_a = 0, last_fall_b = 0;
  int fe_a = 0, se_a = 0, ov_a = 0, ov_b = 0;
  int fe_lat = 0, se_lat = 0, ov_lat = 0;
  exp_t qa[$], qs[$], qr[$], qb[$];

  logic       a_vld, a_l, a_r, a_m, a_xov, a_yov, a_fe, a_se, a_ov;
  logic [8:0] a_dx, a_dy;
  logic [3:0] a_dz;
  logic        s_vld, s_l, s_r, s_m, s_xov, s_yov, s_fe, s_se, s_ov;
  logic [11:0] s_dx, s_dy;
  logic [3:0]  s_dz;
  logic        r_vld, r_l, r_r, r_m, r_xov, r_yov, r_fe, r_se, r_ov;
  logic [11:0] r_dx, r_dy;
  logic [3:0]  r_dz;
  logic       b_vld, b_l, b_r, b_m, b_xov, b_yov, b_fe, b_se, b_ov;
  logic [8:0] b_dx, b_dy;
  logic [3:0] b_dz;

  ps2_mouse_rx #(.TIMEOUT_CYCLES(TO)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_PS2Clk(ps2c_a), .i_PS2Data(ps2d_a), .i_ready(rdy_a),
    .o_valid(a_vld), .o_dx(a_dx), .o_dy(a_dy), .o_dz(a_dz),
    .o_l_click(a_l), .o_r_click(a_r), .o_m_click(a_m), .o_x_ov(a_xov), .o_y_ov(a_yov),
    .o_frame_err(a_fe), .o_sync_err(a_se), .o_overrun(a_ov));

  ps2_mouse_rx #(.DELTA_WIDTH(12), .SATURATE(1'b1), .TIMEOUT_CYCLES(TO)) u_sat (
    .i_clk(clk), .i_reset(rst), .i_PS2Clk(ps2c_a), .i_PS2Data(ps2d_a), .i_ready(rdy_a),
    .o_valid(s_vld), .o_dx(s_dx), .o_dy(s_dy), .o_dz(s_dz),
    .o_l_click(s_l), .o_r_click(s_r), .o_m_click(s_m), .o_x_ov(s_xov), .o_y_ov(s_yov),
    .o_frame_err(s_fe), .o_sync_err(s_se), .o_overrun(s_ov));

  ps2_mouse_rx #(.DELTA_WIDTH(12), .SATURATE(1'b0), .TIMEOUT_CYCLES(TO)) u_raw (
    .i_clk(clk), .i_reset(rst), .i_PS2Clk(ps2c_a), .i_PS2Data(ps2d_a), .i_ready(rdy_a),
    .o_valid(r_vld), .o_dx(r_dx), .o_dy(r_dy), .o_dz(r_dz),
    .o_l_click(r_l), .o_r_click(r_r), .o_m_click(r_m), .o_x_ov(r_xov), .o_y_ov(r_yov),
    .o_frame_err(r_fe), .o_sync_err(r_se), .o_overrun(r_ov));

  ps2_mouse_rx #(.PACKET_BYTES(4), .TIMEOUT_CYCLES(TO)) u_whl (
    .i_clk(clk), .i_reset(rst), .i_PS2Clk(ps2c_b), .i_PS2Data(ps2d_b), .i_ready(rdy_b),
    .o_valid(b_vld), .o_dx(b_dx), .o_dy(b_dy), .o_dz(b_dz),
    .o_l_click(b_l), .o_r_click(b_r), .o_m_click(b_m), .o_x_ov(b_xov), .o_y_ov(b_yov),
    .o_frame_err(b_fe), .o_sync_err(b_se), .o_overrun(b_ov));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [11:0] dx, input logic [11:0] dy, input logic [3:0] dz,
                              input logic [2:0] btn, input logic [1:0] ov);
    exp_t e;
    e.dx = dx; e.dy = dy; e.dz = dz; e.btn = btn; e.ov = ov;
    return e;
  endfunction

  // Same expectation for all three group-A receivers unless the raw one differs.
  task automatic push_a(input exp_t e_sat, input exp_t e_raw);
    qa.push_back(e_sat);
    qs.push_back(e_sat);
    qr.push_back(e_raw);
  endtask

  // Monitors: compare whatever the DUTs hand over against the scoreboard heads.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (a_fe) begin fe_a++; fe_lat = cyc - last_fall_a; end
      if (a_se) begin se_a++; se_lat = cyc - last_fall_a; end
      if (a_ov) ov_a++;
      if (a_vld && rdy_a) begin
        if (qa.size() == 0) chk("a_spurious_valid", 32'(a_vld), 32'd0);
        else begin
          e = qa.pop_front();
          chk("a_dx", 32'(a_dx), 32'(e.dx[8:0]));
          chk("a_dy", 32'(a_dy), 32'(e.dy[8:0]));
          chk("a_dz", 32'(a_dz), 32'(e.dz));
          chk("a_btn", 32'({a_m, a_r, a_l}), 32'(e.btn));
          chk("a_ov", 32'({a_yov, a_xov}), 32'(e.ov));
          chk("a_latency", 32'(cyc - last_fall_a), 32'd4);
        end
      end
      if (s_vld && rdy_a) begin
        if (qs.size() == 0) chk("s_spurious_valid", 32'(s_vld), 32'd0);
        else begin
          e = qs.pop_front();
          chk("s_dx", 32'(s_dx), 32'(e.dx));
          chk("s_dy", 32'(s_dy), 32'(e.dy));
          chk("s_ov", 32'({s_yov, s_xov}), 32'(e.ov));
        end
      end
      if (r_vld && rdy_a) begin
        if (qr.size() == 0) chk("r_spurious_valid", 32'(r_vld), 32'd0);
        else begin
          e = qr.pop_front();
          chk("r_dx", 32'(r_dx), 32'(e.dx));
          chk("r_dy", 32'(r_dy), 32'(e.dy));
          chk("r_ov", 32'({r_yov, r_xov}), 32'(e.ov));
        end
      end
      if (b_ov) begin ov_b++; ov_lat = cyc - last_fall_b; end
      if (b_vld && rdy_b) begin
        if (qb.size() == 0) chk("b_spurious_valid", 32'(b_vld), 32'd0);
        else begin
          e = qb.pop_front();
          chk("b_dx", 32'(b_dx), 32'(e.dx[8:0]));
          chk("b_dy", 32'(b_dy), 32'(e.dy[8:0]));
          chk("b_dz", 32'(b_dz), 32'(e.dz));
          chk("b_btn", 32'({b_m, b_r, b_l}), 32'(e.btn));
        end
      end
    end
  end

  task automatic ps2_bit(input bit grp, input logic d);
    @(negedge clk);
    if (grp) ps2d_b = d; else ps2d_a = d;
    repeat (HALF) @(negedge clk);
    if (grp) begin ps2c_b = 1'b0; last_fall_b = cyc; end
    else     begin ps2c_a = 1'b0; last_fall_a = cyc; end
    repeat (HALF) @(negedge clk);
    if (grp) ps2c_b = 1'b1; else ps2c_a = 1'b1;
  endtask

  task automatic send_frame(input bit grp, input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(grp, f[i]);
    if (grp) ps2d_b = 1'b1; else ps2d_a = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_pkt3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(1'b0, b0, 1'b0, 11);
    send_frame(1'b0, b1, 1'b0, 11);
    send_frame(1'b0, b2, 1'b0, 11);
  endtask

  task automatic send_pkt4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3);
    send_frame(1'b1, b0, 1'b0, 11);
    send_frame(1'b1, b1, 1'b0, 11);
    send_frame(1'b1, b2, 1'b0, 11);
    send_frame(1'b1, b3, 1'b0, 11);
  endtask

  initial begin
    #400000;
    nerr++;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_a_valid", 32'(a_vld), 32'd0);
    chk("rst_a_dx", 32'(a_dx), 32'd0);
    chk("rst_a_err", 32'({a_fe, a_se, a_ov}), 32'd0);
    chk("rst_s_dx", 32'(s_dx), 32'd0);
    chk("rst_b_valid", 32'(b_vld), 32'd0);
    chk("rst_b_dz", 32'(b_dz), 32'd0);

    // Basic packet: left click, dx +5, dy -5.
    push_a(mk(12'h005, 12'hFFB, 4'h0, 3'b001, 2'b00), mk(12'h005, 12'hFFB, 4'h0, 3'b001, 2'b00));
    send_pkt3(8'h29, 8'h05, 8'hFB);
    chk("pkt1_drained", 32'(qa.size()), 32'd0);

    // Parity error on byte 2 aborts the packet.
    send_frame(1'b0, 8'h08, 1'b0, 11);
    send_frame(1'b0, 8'h01, 1'b0, 11);
    send_frame(1'b0, 8'h02, 1'b1, 11);
    chk("parity_fe_count", 32'(fe_a), 32'd1);
    chk("parity_fe_latency", 32'(fe_lat), 32'd3);
    push_a(mk(12'h001, 12'h001, 4'h0, 3'b000, 2'b00), mk(12'h001, 12'h001, 4'h0, 3'b000, 2'b00));
    send_pkt3(8'h08, 8'h01, 8'h01);

    // Byte 0 without bit 3 is rejected.
    send_frame(1'b0, 8'h00, 1'b0, 11);
    chk("sync_count", 32'(se_a), 32'd1);
    chk("sync_latency", 32'(se_lat), 32'd3);
    chk("sync_no_fe", 32'(fe_a), 32'd1);
    push_a(mk(12'h002, 12'h003, 4'h0, 3'b001, 2'b00), mk(12'h002, 12'h003, 4'h0, 3'b001, 2'b00));
    send_pkt3(8'h09, 8'h02, 8'h03);

    // X overflow, negative: saturated vs raw.
    push_a(mk(12'hF00, 12'h000, 4'h0, 3'b000, 2'b01), mk(12'hF10, 12'h000, 4'h0, 3'b000, 2'b01));
    send_pkt3(8'h58, 8'h10, 8'h00);

    // Partial frame then idle: one timeout error, then a clean packet.
    send_frame(1'b0, 8'h08, 1'b0, 5);
    repeat (TO + 50) @(negedge clk);
    chk("timeout_fe_count", 32'(fe_a), 32'd2);
    push_a(mk(12'h07F, 12'h080, 4'h0, 3'b000, 2'b00), mk(12'h07F, 12'h080, 4'h0, 3'b000, 2'b00));
    send_pkt3(8'h08, 8'h7F, 8'h80);

    // Reset mid-frame discards the partial frame without raising a timeout.
    send_frame(1'b0, 8'h08, 1'b0, 5);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (TO + 50) @(negedge clk);
    chk("reset_no_timeout", 32'(fe_a), 32'd2);
    push_a(mk(12'hFFF, 12'h001, 4'h0, 3'b000, 2'b00), mk(12'hFFF, 12'h001, 4'h0, 3'b000, 2'b00));
    send_pkt3(8'h18, 8'hFF, 8'h01);

    // Wheel receiver with a stalled consumer.
    qb.push_back(mk(12'h001, 12'h002, 4'hF, 3'b000, 2'b00));
    send_pkt4(8'h08, 8'h01, 8'h02, 8'h0F);
    chk("whl_valid_held", 32'(b_vld), 32'd1);
    chk("whl_dz", 32'(b_dz), 32'hF);
    send_pkt4(8'h08, 8'h03, 8'h04, 8'h01);
    chk("whl_overrun_count", 32'(ov_b), 32'd1);
    chk("whl_overrun_latency", 32'(ov_lat), 32'd4);
    chk("whl_hold_dx", 32'(b_dx), 32'h001);
    chk("whl_hold_dz", 32'(b_dz), 32'hF);
    @(posedge clk); #1 rdy_b = 1'b1;
    @(posedge clk); #1 rdy_b = 1'b0;
    @(negedge clk);
    chk("whl_valid_drop", 32'(b_vld), 32'd0);

    repeat (20) @(negedge clk);
    chk("qa_empty", 32'(qa.size()), 32'd0);
    chk("qs_empty", 32'(qs.size()), 32'd0);
    chk("qr_empty", 32'(qr.size()), 32'd0);
    chk("qb_empty", 32'(qb.size()), 32'd0);
    chk("a_no_overrun", 32'(ov_a), 32'd0);
    chk("a_sync_total", 32'(se_a), 32'd1);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_rx.md
# ps2_mouse_rx

Parametrised PS/2 mouse packet receiver. Samples the raw PS/2 clock and data lines in receive-only mode and checks each 11-bit frame for start, parity and stop errors. Assembles 3-byte standard or 4-byte wheel packets with a frame-timeout resync, and presents sign-extended, optionally saturated movement deltas through a valid/ready handshake. It is the next generation of the mouse front end, feeding the cursor and click logic.

## Interface
- PACKET_BYTES, 3, packet length: 3 (standard) or 4 (wheel mouse); other values illegal
- DELTA_WIDTH, 9, width of o_dx/o_dy, must be >= 9
- SATURATE, 1, 1: overflow bit forces full-scale delta; 0: raw 9-bit value passed through
- TIMEOUT_CYCLES, 20000, i_clk cycles without a PS/2 falling edge before a partial frame/packet is discarded
- SYNC_STAGES, 2, synchroniser depth on both PS/2 inputs, >= 2

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_PS2Clk  in  1  raw PS/2 clock (asynchronous)
- i_PS2Data  in  1  raw PS/2 data (asynchronous)
- i_ready  in  1  consumer accepts the packet when high with o_valid
- o_valid  out  1  packet registers hold an unconsumed packet
- o_dx  out  DELTA_WIDTH  X delta, two's complement, positive right
- o_dy  out  DELTA_WIDTH  Y delta, two's complement, positive up (device convention)
- o_dz  out  4  wheel delta, two's complement; 0 when PACKET_BYTES=3
- o_l_click, o_r_click, o_m_click  out  1 each  button states from byte 0 bits 0, 1, 2
- o_x_ov, o_y_ov  out  1 each  byte 0 bits 6, 7
- o_frame_err  out  1  one-cycle pulse: start/parity/stop error or timeout
- o_sync_err  out  1  one-cycle pulse: byte 0 rejected (bit 3 = 0)
- o_overrun  out  1  one-cycle pulse: completed packet dropped because output full

## Operation
- Both PS/2 inputs pass through SYNC_STAGES flops. A falling edge is defined as previous synchronised clock = 1 and current = 0. Data is sampled from the synchronised data line in the same cycle.
- Frame: 11 bits, LSB-first: start(0), d0..d7, odd parity, stop(1). A 4-bit counter counts 0..10.
- After the 11th bit, check: start = 0, XOR(d0..d7, parity) = 1, stop = 1. Any failure pulses o_frame_err and returns the byte index to 0, discarding the partial packet.
- Byte index 0: the byte is accepted only if bit 3 = 1. Otherwise o_sync_err pulses and the index stays at 0.
- Bytes are stored in index order. Reaching index PACKET_BYTES completes the packet.
- Decode:
  - dx = {byte0[4], byte1} as 9-bit two's complement, sign-extended to DELTA_WIDTH.
  - dy = {byte0[5], byte2}, treated the same way.
  - dz = byte3[3:0].
- SATURATE=1 and overflow bit set: the delta is forced to +255 if sign = 0, or −256 if sign = 1, then sign-extended. The overflow flags are output unchanged in both modes.
- Timeout counter:
  - Cleared on every falling edge and held at 0 while bit count = 0 and byte index = 0.
  - Otherwise increments each cycle.
  - Reaching TIMEOUT_CYCLES: bit count and byte index go to 0, o_frame_err pulses, counter clears.
- Output stage (one entry):
  - Completion with o_valid = 0: load the packet.
  - Completion with o_valid = 1 and i_ready = 1: load the new packet; o_valid stays 1.
  - Completion with o_valid = 1 and i_ready = 0: drop the new packet, pulse o_overrun; held data unchanged.
  - o_valid & i_ready without completion: o_valid → 0; data registers keep their values.
- Error pulses may coincide. o_frame_err and o_sync_err are never both asserted for the same byte.

## Timing
- Reset: all outputs 0, counters 0, byte index 0, synchronisers 1 (idle bus). Reset mid-frame or mid-packet discards everything; the first falling edge after reset is treated as a start bit.
- Let E be the cycle the 11th falling edge is detected. The check result is registered at E+1, and error pulses appear at E+1.
- Packet latency: o_valid and data registers are updated at E+2 for the last byte of the packet.
- o_overrun is asserted at E+2.
- o_dx/o_dy/o_dz/buttons/flags are stable while o_valid = 1.
- Handshake: a transfer happens on a rising clock with o_valid & i_ready. i_ready may be high while o_valid is low, with no effect.
- Timeout pulse appears in the cycle the counter equals TIMEOUT_CYCLES.

## Test plan
- Defaults; bytes 0x29, 0x05, 0xFB with correct parity, i_ready = 1 → o_valid for 1 cycle at E+2 of byte 3; o_dx = 9'h005, o_dy = 9'h1FB (−5), o_l_click = 1, others 0.
- Byte 2 sent with wrong parity → o_frame_err at E+1, no o_valid; the next clean packet 0x08, 0x01, 0x01 → o_dx = 1, o_dy = 1.
- Byte 0 = 0x00 → o_sync_err, index stays 0; then 0x09, 0x02, 0x03 → o_dx = 2, o_dy = 3, o_l_click = 1.
- SATURATE = 1, DELTA_WIDTH = 12; bytes 0x58, 0x10, 0x00 → o_dx = 12'hF00 (−256), o_x_ov = 1, o_dy = 0. SATURATE = 0 with the same bytes → o_dx = 12'hF10.
- Send 5 bits of a frame, then idle TIMEOUT_CYCLES → o_frame_err once; the following clean packet decodes correctly. Assert i_reset mid-frame → same clean result.
- PACKET_BYTES = 4, i_ready = 0; send two packets (the first with byte 3 = 0x0F) → the second raises o_overrun. Outputs keep o_dz = 4'hF (−1) until i_ready pulses, then o_valid = 0.
